ofifo_col: RTL and testbench
============================

Name: ofifo_col

Overview:
- Output FIFO directly downstream of the MAC row array.
- Holds one independent circular buffer per column. Each buffer captures that column's partial sum (psum) whenever its per-column valid strobe fires; columns arrive skewed in time.
- Presents a row-aligned output word only when every column holds data.
- Consumer (SFU / accumulation SRAM writer) pops all columns together with a single read strobe.

Parameters:
- col, 8, number of columns (one buffer each).
- psum_bw, 16, width of each column's psum entry.
- depth, 64, entries per column buffer. Must be a power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in  input  psum_bw*col  column psums. Column i occupies bits [psum_bw*i +: psum_bw]; driven from the array's south outputs.
- wr  input  col  per-column write strobe; driven from the array's per-column valid.
- rd  input  1  pop one row from all columns.
- out  output  psum_bw*col  registered row data, same column packing as in.
- o_valid  output  1  every column buffer is non-empty.
- o_full  output  1  at least one column buffer is full.
- o_ready  output  1  equals ~o_full.
- o_overflow  output  1  sticky: a write was dropped.

Behaviour:
- Per column: write pointer and read pointer, each log2(depth)+1 bits; the MSB is the wrap bit.
  - empty_i = (wptr_i == rptr_i).
  - full_i = (low bits equal) && (wrap bits differ).
  - Pointers wrap modulo 2*depth naturally.
- Write, column i: when wr[i] && !full_i, at the clock edge:
  - mem_i[wptr_i] <= in[column i];
  - wptr_i increments.
- Write while full: when wr[i] && full_i, the data is dropped, wptr_i holds, and o_overflow sets. o_overflow stays set until reset.
- full_i is the registered state at the start of the cycle. A simultaneous pop does NOT free a slot for a same-cycle write. This holds for all columns and all cases.
- o_valid = AND of ~empty_i over all columns. o_full = OR of full_i over all columns. Both are combinational from the pointer registers.
- Read: when rd && o_valid, at the clock edge:
  - every rptr_i increments;
  - out <= concatenation of mem_i[rptr_i] (pre-increment values).
  - Latency: data is visible on out one cycle after rd is sampled.
- rd && !o_valid is ignored: pointers and out hold. This is not an error.
- When not reading, out holds its last value.
- Same-cycle write and read on a non-empty column: both take effect. Occupancy is unchanged. The word read is the old head, never the word being written.
- A write into an empty column does not affect o_valid until the next cycle (no bypass).
- Columns fill independently. The skew between column i and column i+1 is absorbed by the buffers.
- Reset (asserted at any time, including mid-burst), asynchronously:
  - all pointers <= 0;
  - out <= 0;
  - o_overflow <= 0;
  - therefore o_valid = 0, o_full = 0, o_ready = 1.
  - Memory contents are not reset, and are unobservable after reset.
- Occupancy invariant per column: 0 <= wptr_i - rptr_i (mod 2*depth) <= depth.

Optional Feature:
- Macro OFIFO_COL_RELU_EN.
- Defined: on pop, each column's word is treated as signed two's complement. A negative value is replaced by 0 before being registered into out; non-negative values pass unchanged.
- Not defined: out carries the raw stored psums.
- Pointer, flag and latency behaviour are identical in both builds.

Test Plan:
- Reset check: hold reset=0 with random in/wr/rd -> out=0, o_valid=0, o_full=0, o_ready=1, o_overflow=0. Release reset -> all flags unchanged.
- Skewed fill:
  - Pulse wr[i] at cycle t+i (col=8) with value 16'h0100+i.
  - o_valid rises the cycle after the wr[7] edge.
  - rd=1 for one cycle -> next cycle, out column i = 16'h0100+i, and o_valid=0.
- Fill to full and overflow:
  - wr[0]=1 for 65 consecutive cycles (depth=64) with values 0..64.
  - o_full=1 after the 64th write.
  - The 65th write is dropped and o_overflow=1.
  - Fill the other columns, then pop 64 times -> column 0 returns 0..63; value 64 is never seen.
- Read while empty: rd=1 with only columns 0-6 loaded -> out unchanged, all pointers unchanged. Then load column 7 and pop -> correct row.
- Wrap-around: 200 streaming rows with wr on all columns and rd whenever o_valid -> in-order data, no overflow. Pointers wrap past 128 correctly.
- Mid-operation reset plus ReLU:
  - With OFIFO_COL_RELU_EN, a popped entry of 16'hFFF6 gives out=0, and 16'h000A gives 16'h000A.
  - Assert reset with 10 rows buffered -> o_valid=0 immediately and out=0.

Source files
------------

// File: rtl/ofifo_col.sv
// Column-skew output FIFO: one circular buffer per column, row pops when all columns hold data (1-cycle registered read).
// Full columns drop writes and set sticky o_overflow; optional OFIFO_COL_RELU_EN clamps negative popped psums to zero.
module ofifo_col #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [psum_bw*col-1:0]   in,
   input  logic [col-1:0]           wr,
   input  logic                     rd,
   output logic [psum_bw*col-1:0]   out,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_ready,
   output logic                     o_overflow
);

   localparam int aw = $clog2(depth);

   logic [col-1:0] empty;
   logic [col-1:0] full;
   logic [col-1:0] ovf_hit;
   logic           pop;

   assign o_valid = ~|empty;
   assign o_full  = |full;
   assign o_ready = ~o_full;
   assign pop     = rd && o_valid;

   for (genvar i = 0; i < col; i++) begin : g_col
      logic [aw:0]          wptr;
      logic [aw:0]          rptr;
      logic [psum_bw-1:0]   mem [depth];
      logic [psum_bw-1:0]   head;
      logic [psum_bw-1:0]   pop_dat;
      logic [psum_bw-1:0]   q;
      logic                 wr_ok;

      assign empty[i]   = (wptr == rptr);
      assign full[i]    = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
      // full is the start-of-cycle state, so a same-cycle pop never frees room for this write
      assign wr_ok      = wr[i] && !full[i];
      assign ovf_hit[i] = wr[i] && full[i];
      assign head       = mem[rptr[aw-1:0]];

`ifdef OFIFO_COL_RELU_EN
      assign pop_dat = head[psum_bw-1] ? '0 : head;
`else
      assign pop_dat = head;
`endif

      always_ff @(posedge clk) begin
         if (wr_ok) begin
            mem[wptr[aw-1:0]] <= in[psum_bw*i +: psum_bw];
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            q    <= '0;
         end else begin
            if (wr_ok) begin
               wptr <= wptr + 1'b1;
            end
            if (pop) begin
               rptr <= rptr + 1'b1;
               q    <= pop_dat;
            end
         end
      end

      assign out[psum_bw*i +: psum_bw] = q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_overflow <= 1'b0;
      end else if (|ovf_hit) begin
         o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo_col.sv
// Directed bench for ofifo_col: skew table plus hand-written full/overflow, empty-read, wrap and reset/ReLU sequences.
module tb_ofifo_col;

   logic         clk;
   logic         reset;
   logic [127:0] din;
   logic [7:0]   wr;
   logic         rd;
   logic [127:0] dout;
   logic         o_valid;
   logic         o_full;
   logic         o_ready;
   logic         o_overflow;

   int checks   = 0;
   int failures = 0;

   ofifo_col dut (
      .clk        (clk),
      .reset      (reset),
      .in         (din),
      .wr         (wr),
      .rd         (rd),
      .out        (dout),
      .o_valid    (o_valid),
      .o_full     (o_full),
      .o_ready    (o_ready),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]   wr;
      logic         rd;
      logic         exp_valid;
      logic [127:0] exp_out;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr    = '0;
      rd    = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   function automatic logic [127:0] relu_row(input logic [127:0] r);
      logic [127:0] o;
      o = r;
`ifdef OFIFO_COL_RELU_EN
      for (int j = 0; j < 8; j++) begin
         if (o[16*j+15]) o[16*j +: 16] = 16'h0000;
      end
`endif
      return o;
   endfunction

   function automatic logic [127:0] mk_row(input int base, input int k);
      logic [127:0] r;
      for (int j = 0; j < 8; j++) r[16*j +: 16] = 16'(base * j + k);
      return r;
   endfunction

   vec_t         tv[9];
   logic [127:0] skew_row;
   logic [127:0] exp_row;
   logic [127:0] q[$];
   int           n;

   initial begin
      din   = '0;
      wr    = '0;
      rd    = 1'b0;
      reset = 1'b0;

      // reset held with random activity
      for (int c = 0; c < 5; c++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         wr  = 8'($urandom);
         rd  = 1'($urandom);
         step();
         chk("rst_out", dout, '0);
         chk("rst_valid", {127'd0, o_valid}, 128'd0);
         chk("rst_full", {127'd0, o_full}, 128'd0);
         chk("rst_ready", {127'd0, o_ready}, 128'd1);
         chk("rst_ovf", {127'd0, o_overflow}, 128'd0);
      end
      wr = '0; rd = 1'b0;
      reset = 1'b1;
      step();
      chk("rel_out", dout, '0);
      chk("rel_valid", {127'd0, o_valid}, 128'd0);
      chk("rel_ready", {127'd0, o_ready}, 128'd1);
      chk("rel_ovf", {127'd0, o_overflow}, 128'd0);

      // skewed fill table
      for (int j = 0; j < 8; j++) skew_row[16*j +: 16] = 16'(16'h0100 + j);
      for (int k = 0; k < 8; k++) tv[k] = '{wr: 8'(1 << k), rd: 1'b0, exp_valid: (k == 7), exp_out: '0};
      tv[8] = '{wr: 8'h00, rd: 1'b1, exp_valid: 1'b0, exp_out: skew_row};
      din = skew_row;
      for (int k = 0; k < 9; k++) begin
         wr = tv[k].wr;
         rd = tv[k].rd;
         step();
         chk($sformatf("skew_valid[%0d]", k), {127'd0, o_valid}, {127'd0, tv[k].exp_valid});
         chk($sformatf("skew_out[%0d]", k), dout, tv[k].exp_out);
         chk($sformatf("skew_ready[%0d]", k), {127'd0, o_ready}, 128'd1);
      end
      wr = '0; rd = 1'b0;

      // fill column 0 to full and overflow it
      do_reset();
      din = '0;
      for (int k = 0; k < 65; k++) begin
         wr = 8'h01;
         din[15:0] = 16'(k);
         step();
         if (k == 62) chk("full_before", {127'd0, o_full}, 128'd0);
         if (k == 63) begin
            chk("full_64", {127'd0, o_full}, 128'd1);
            chk("ready_64", {127'd0, o_ready}, 128'd0);
            chk("ovf_64", {127'd0, o_overflow}, 128'd0);
         end
         if (k == 64) chk("ovf_65", {127'd0, o_overflow}, 128'd1);
      end
      for (int k = 0; k < 64; k++) begin
         wr  = 8'hFE;
         din = mk_row(16'h1000, k);
         din[15:0] = 16'hDEAD;
         step();
      end
      wr = '0;
      chk("fill_valid", {127'd0, o_valid}, 128'd1);
      rd = 1'b1;
      for (int k = 0; k < 64; k++) begin
         step();
         chk($sformatf("fill_pop[%0d]", k), dout, relu_row(mk_row(16'h1000, k)));
      end
      chk("drain_valid", {127'd0, o_valid}, 128'd0);
      step();
      chk("hold_out", dout, relu_row(mk_row(16'h1000, 63)));
      chk("ovf_sticky", {127'd0, o_overflow}, 128'd1);
      rd = 1'b0;

      // read while not all columns loaded
      do_reset();
      din = mk_row(1, 16'h2000);
      wr  = 8'h7F;
      step();
      wr = '0; rd = 1'b1;
      step();
      chk("empty_rd_out", dout, '0);
      chk("empty_rd_valid", {127'd0, o_valid}, 128'd0);
      rd = 1'b0; wr = 8'h80;
      step();
      wr = '0;
      chk("col7_valid", {127'd0, o_valid}, 128'd1);
      rd = 1'b1;
      step();
      rd = 1'b0;
      chk("col7_pop", dout, relu_row(mk_row(1, 16'h2000)));
      chk("col7_after", {127'd0, o_valid}, 128'd0);

      // streaming wrap-around
      do_reset();
      q.delete();
      n = 0;
      for (int c = 0; c < 260; c++) begin
         rd = (q.size() > 0);
         wr = (n < 200) ? 8'hFF : 8'h00;
         for (int j = 0; j < 8; j++) din[16*j +: 16] = {n[11:0], 4'(j)};
         step();
         if (rd) begin
            exp_row = q.pop_front();
            chk($sformatf("wrap_out[%0d]", c), dout, relu_row(exp_row));
         end
         if (n < 200) begin
            q.push_back(din);
            n++;
         end
         chk($sformatf("wrap_valid[%0d]", c), {127'd0, o_valid}, {127'd0, (q.size() > 0)});
      end
      rd = 1'b0; wr = '0;
      chk("wrap_ovf", {127'd0, o_overflow}, 128'd0);
      chk("wrap_count", 128'(n), 128'd200);

      // signed psums then mid-burst reset
      do_reset();
      for (int j = 0; j < 8; j++) din[16*j +: 16] = (j % 2 == 0) ? 16'hFFF6 : 16'h000A;
      exp_row = din;
      wr = 8'hFF;
      step();
      wr = '0; rd = 1'b1;
      step();
      rd = 1'b0;
      chk("relu_pop", dout, relu_row(exp_row));
      wr = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         din = mk_row(3, k);
         step();
      end
      wr = '0;
      chk("pre_rst_valid", {127'd0, o_valid}, 128'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_valid", {127'd0, o_valid}, 128'd0);
      chk("midrst_out", dout, '0);
      chk("midrst_ready", {127'd0, o_ready}, 128'd1);
      step();
      reset = 1'b1;
      step();
      chk("postrst_valid", {127'd0, o_valid}, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
